// File: rtl/rule_install_ctrl_pkg.sv
// Shared types and default sizing for the rule install controller.
// Holds the install FSM state encoding and the default table geometry.
package rule_install_ctrl_pkg;

   localparam int DEF_ENTRIES  = 16;
   localparam int DEF_KEY_W    = 128;
   localparam int DEF_ACTION_W = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HOLD    = 3'd1,
      WR_ACT  = 3'd2,
      WR_KEY  = 3'd3,
      WR_MASK = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/rule_install_ctrl_if.sv
// Install request channel: one instance per requester.
// valid/ready: a transfer happens in a cycle where both are high; the requester
// keeps valid and the payload (addr/key/mask/action) stable until that cycle.
interface rule_install_ctrl_if
   import rule_install_ctrl_pkg::*;
#(
   parameter int ADDR_W   = $clog2(DEF_ENTRIES),
   parameter int KEY_W    = DEF_KEY_W,
   parameter int ACTION_W = DEF_ACTION_W
);
   logic                valid;
   logic                ready;
   logic [ADDR_W-1:0]   addr;
   logic [KEY_W-1:0]    key;
   logic [KEY_W-1:0]    mask;
   logic [ACTION_W-1:0] action;

   modport master (output valid, output addr, output key, output mask, output action,
                   input ready);
   modport slave  (input valid, input addr, input key, input mask, input action,
                   output ready);
endinterface

// File: rtl/rule_install_ctrl_arb.sv
// Two-requester arbiter with one-hot grant. Round-robin when RULE_INSTALL_RR_EN
// is defined, otherwise fixed priority with requester 0 winning ties.
module rule_install_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);
`ifdef RULE_INSTALL_RR_EN
   // ptr names the requester favoured on the next tie
   logic ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (accept) begin
         ptr <= ~grant[1];
      end
   end

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst_n, accept};

   always_comb begin
      grant = {req[1] & ~req[0], req[0]};
   end
`endif
endmodule

// File: rtl/rule_install_ctrl.sv
// Installs TCAM key/mask and action entries while holding off lookups.
// Arbitration mode is selected by the RULE_INSTALL_RR_EN macro.
module rule_install_ctrl
   import rule_install_ctrl_pkg::*;
#(
   parameter int  ENTRIES  = DEF_ENTRIES,
   parameter int  KEY_W    = DEF_KEY_W,
   parameter int  ACTION_W = DEF_ACTION_W,
   localparam int ADDR_W   = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                rst_n,
   rule_install_ctrl_if.slave  req0,
   rule_install_ctrl_if.slave  req1,
   input  logic                lookup_busy,
   output logic                lookup_hold,
   output logic                tcam_wr_en,
   output logic                tcam_wr_is_mask,
   output logic [ADDR_W-1:0]   tcam_wr_addr,
   output logic [KEY_W-1:0]    tcam_wr_data,
   output logic                action_wr_en,
   output logic [ADDR_W-1:0]   action_wr_addr,
   output logic [ACTION_W-1:0] action_wr_data,
   output logic                install_done,
   output logic                install_src,
   output state_t              state_dbg
);
   state_t              state_q, state_d;
   logic [1:0]          req_vec, grant;
   logic                accept;
   logic                src_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [KEY_W-1:0]    key_q, mask_q;
   logic [ACTION_W-1:0] action_q;

   // Requests are only offered to the arbiter while idle and out of reset
   assign req_vec = (state_q == IDLE && rst_n) ? {req1.valid, req0.valid} : 2'b00;
   assign accept  = |grant;

   rule_install_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_vec),
      .accept (accept),
      .grant  (grant)
   );

   assign req0.ready = grant[0];
   assign req1.ready = grant[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_q    <= 1'b0;
         addr_q   <= '0;
         key_q    <= '0;
         mask_q   <= '0;
         action_q <= '0;
      end else if (accept) begin
         src_q <= grant[1];
         if (grant[1]) begin
            addr_q   <= req1.addr;
            key_q    <= req1.key;
            mask_q   <= req1.mask;
            action_q <= req1.action;
         end else begin
            addr_q   <= req0.addr;
            key_q    <= req0.key;
            mask_q   <= req0.mask;
            action_q <= req0.action;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs decode the state register only, so lookup_busy never reaches lookup_hold
   always_comb begin
      state_d         = state_q;
      lookup_hold     = 1'b1;
      action_wr_en    = 1'b0;
      tcam_wr_en      = 1'b0;
      tcam_wr_is_mask = 1'b0;
      install_done    = 1'b0;
      case (state_q)
         IDLE: begin
            lookup_hold = 1'b0;
            if (accept) state_d = HOLD;
         end
         HOLD: begin
            if (!lookup_busy) state_d = WR_ACT;
         end
         WR_ACT: begin
            action_wr_en = 1'b1;
            state_d      = WR_KEY;
         end
         WR_KEY: begin
            tcam_wr_en = 1'b1;
            state_d    = WR_MASK;
         end
         WR_MASK: begin
            tcam_wr_en      = 1'b1;
            tcam_wr_is_mask = 1'b1;
            state_d         = DONE;
         end
         DONE: begin
            install_done = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign tcam_wr_addr   = addr_q;
   assign tcam_wr_data   = tcam_wr_is_mask ? mask_q : key_q;
   assign action_wr_addr = addr_q;
   assign action_wr_data = action_q;
   assign install_src    = src_q;
   assign state_dbg      = state_q;

endmodule

// File: doc/rule_install_ctrl.md
RULE_INSTALL_CTRL -- requirements
Module: rule_install_ctrl

Interface
REQ-001 Param ENTRIES, 16, number of TCAM/action entries (power of two).
REQ-002 Param KEY_W, 128, TCAM key/mask width.
REQ-003 Param ACTION_W, 64, action word width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 reqN_valid / reqN_ready (N=0,1)  in / out  1 / 1  install request handshake per requester.
REQ-007 reqN_addr  in  log2(ENTRIES)  target entry index.
REQ-008 reqN_key / reqN_mask  in  KEY_W / KEY_W  rule value / care mask.
REQ-009 reqN_action  in  ACTION_W  action word for the entry.
REQ-010 lookup_busy  in  1  a lookup is in flight in the parser/TCAM pipeline.
REQ-011 lookup_hold  out  1  stalls new lookups while a rule is being rewritten.
REQ-012 tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data  out  1,1,log2(ENTRIES),KEY_W  TCAM write port.
REQ-013 action_wr_en, action_wr_addr, action_wr_data  out  1,log2(ENTRIES),ACTION_W  action memory write port.
REQ-014 install_done  out  1  one-cycle pulse when an install completes; install_src  out  1  requester index of that install.

Function
REQ-015 FSM states SHALL be IDLE, HOLD, WR_ACT, WR_KEY, WR_MASK, DONE.
REQ-016 In IDLE, if any reqN_valid, arbiter SHALL grant one requester, assert its reqN_ready that cycle, capture addr/key/mask/action and source index, go to HOLD.
REQ-017 reqN_ready SHALL be high only in IDLE for the granted requester; never both high.
REQ-018 HOLD SHALL stay while lookup_busy=1 and go to WR_ACT when lookup_busy=0 (minimum one cycle in HOLD).
REQ-019 WR_ACT: action_wr_en=1 with captured addr/action, one cycle, then WR_KEY.
REQ-020 WR_KEY: tcam_wr_en=1, tcam_wr_is_mask=0, data=captured key, one cycle, then WR_MASK.
REQ-021 WR_MASK: tcam_wr_en=1, tcam_wr_is_mask=1, data=captured mask, one cycle, then DONE.
REQ-022 DONE: install_done=1, install_src=captured source, one cycle, then IDLE.
REQ-023 lookup_hold SHALL be 1 in every state except IDLE (registered from state, no combinational path from lookup_busy).
REQ-024 Latency with lookup_busy=0: accept at T, action write T+2, key T+3, mask T+4, install_done T+5, next accept possible T+6.
REQ-025 Write enables SHALL be low in all other states; write data/addr outputs don't-care when enables low.
REQ-026 Requests arriving while not IDLE SHALL wait (ready=0); requester must hold payload stable until ready.
REQ-027 Simultaneous valid on both requesters SHALL resolve per REQ-031/REQ-032 in the same cycle.

Reset
REQ-028 On rst_n=0 at a clock edge: state=IDLE, all reqN_ready, write enables, lookup_hold, install_done = 0; install_src=0; captured payload cleared; RR pointer set so requester 0 wins next tie.
REQ-029 Reset mid-install SHALL abort without further writes; partially written entry is not restored.

Configuration
REQ-030 Macro RULE_INSTALL_RR_EN selects arbitration.
REQ-031 Defined: round-robin; on tie, grant the requester not granted last; pointer updates only on accept.
REQ-032 Undefined: fixed priority, requester 0 always wins ties; no pointer register.

Structure
REQ-033 Shared package SHALL hold FSM state encoding and default ENTRIES/KEY_W/ACTION_W constants.
REQ-034 Arbiter SHALL be a sub-module rule_install_arb (2 requests in, one-hot grant out, accept strobe in).

Verification
REQ-035 req0 addr=5, key=0xC0A8_0001.., mask=0xFFFF_FFFF.., action=0x1, lookup_busy=0 -> action write T+2, key T+3, mask T+4 (is_mask=1), install_done T+5 src=0.
REQ-036 lookup_busy held high 4 cycles after accept -> lookup_hold=1 throughout, no writes until busy falls, action write one cycle later.
REQ-037 Both requesters valid continuously, RR_EN defined -> grants alternate 0,1,0,1; undefined -> four consecutive installs all src=0.
REQ-038 req1 valid mid-install of req0 -> req1_ready stays 0 until IDLE, then accepted at T+6, payload captured unchanged.
REQ-039 rst_n low during WR_KEY -> next cycle all enables/lookup_hold 0, no WR_MASK, no install_done; new request accepted after release.
